// File: rtl/osd_dii_pkg.sv
// Shared types for the DII store-and-forward packet buffer.
package osd_dii_pkg;

    localparam int DII_FLIT_W = 16;

    typedef struct packed {
        logic                  last;
        logic [DII_FLIT_W-1:0] data;
    } dii_flit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STORE = 2'd1,
        DROP  = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/osd_dii_fifo_ram.sv
// Flit storage: registered write port, combinational read port, no reset on the array.
module osd_dii_fifo_ram
    import osd_dii_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  dii_flit_t     wdata_i,
    input  logic [AW-1:0] raddr_i,
    output dii_flit_t     rdata_o
);

    dii_flit_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/osd_dii_pkt_fifo.sv
// Store-and-forward DII packet buffer: a packet is offered to the ring only once
// its last flit is stored; oversized packets are dropped and broken framing is repaired.
module osd_dii_pkt_fifo
    import osd_dii_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DII_FLIT_W-1:0] in_data,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DII_FLIT_W-1:0] out_data,
    output logic                  out_first,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      drop_count,
    output logic [CNT_W-1:0]      err_count,
    output fsm_state_e            dbg_state_o,
    output logic [CW-1:0]         dbg_used_o
);

    // Handshake: a flit moves on a side only in a cycle where valid and ready are
    // both high at the rising clock edge; valid never waits on ready.

    localparam logic [AW-1:0] ONE_A   = AW'(1);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fsm_state_e       state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    wr_start_q, wr_start_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    used_q, used_d;
    logic [CW-1:0]    cur_len_q, cur_len_d;
    logic [CW-1:0]    pkt_cnt_q, pkt_cnt_d;
    logic             out_first_q, out_first_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] err_q, err_d;

    logic             has_free;
    logic             pkt_avail;
    logic             ready_c;
    logic             accept;
    logic             pop;
    logic             pop_last;
    logic             we;
    logic [AW-1:0]    waddr;
    logic             push;
    logic [CW-1:0]    rewind;
    logic             pkt_inc;
    logic             err_inc;
    logic             drop_inc;
    dii_flit_t        wdata;
    dii_flit_t        rdata;

    osd_dii_fifo_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    assign has_free  = (used_q != DEPTH_C);
    assign pkt_avail = (pkt_cnt_q != '0);
    assign in_ready  = ready_c & ~rst;
    assign accept    = in_valid & in_ready;
    assign pop       = pkt_avail & out_ready;
    assign pop_last  = pop & rdata.last;
    assign wdata     = '{last: in_last, data: in_data};

    assign out_valid   = pkt_avail;
    assign out_data    = rdata.data;
    assign out_last    = rdata.last;
    assign out_first   = out_first_q;
    assign drop_count  = drop_q;
    assign err_count   = err_q;
    assign dbg_state_o = state_q;
    assign dbg_used_o  = used_q;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        wr_start_d = wr_start_q;
        cur_len_d  = cur_len_q;
        we         = 1'b0;
        waddr      = wr_ptr_q;
        push       = 1'b0;
        rewind     = '0;
        pkt_inc    = 1'b0;
        err_inc    = 1'b0;
        drop_inc   = 1'b0;

        case (state_q)
            IDLE:    ready_c = has_free | ~in_first;
            STORE:   ready_c = has_free | ~pkt_avail;
            DROP:    ready_c = 1'b1;
            default: ready_c = 1'b0;
        endcase

        if (accept) begin
            if (state_q == STORE) begin
                if (in_first) begin
                    // Restart: discard the unfinished packet and reuse its slot.
                    err_inc  = 1'b1;
                    rewind   = cur_len_q;
                    we       = 1'b1;
                    waddr    = wr_start_q;
                    wr_ptr_d = wr_start_q + ONE_A;
                    cur_len_d = ONE_C;
                    push     = 1'b1;
                    if (in_last) begin
                        pkt_inc = 1'b1;
                        state_d = IDLE;
                    end
                end else if (has_free) begin
                    we        = 1'b1;
                    wr_ptr_d  = wr_ptr_q + ONE_A;
                    cur_len_d = cur_len_q + ONE_C;
                    push      = 1'b1;
                    if (in_last) begin
                        pkt_inc = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    // Buffer holds only this packet and it still does not fit.
                    rewind    = cur_len_q;
                    wr_ptr_d  = wr_start_q;
                    cur_len_d = '0;
                    drop_inc  = 1'b1;
                    state_d   = in_last ? IDLE : DROP;
                end
            end else if (in_first) begin
                err_inc = (state_q == DROP);
                if (has_free) begin
                    we         = 1'b1;
                    wr_start_d = wr_ptr_q;
                    wr_ptr_d   = wr_ptr_q + ONE_A;
                    cur_len_d  = ONE_C;
                    push       = 1'b1;
                    pkt_inc    = in_last;
                    state_d    = in_last ? IDLE : STORE;
                end else begin
                    state_d = IDLE;
                end
            end else begin
                if (state_q == IDLE) begin
                    err_inc = 1'b1;
                end else if (in_last) begin
                    state_d = IDLE;
                end
            end
        end

        rd_ptr_d    = pop ? rd_ptr_q + ONE_A : rd_ptr_q;
        out_first_d = pop ? rdata.last : out_first_q;
        used_d      = used_q + (push ? ONE_C : '0) - (pop ? ONE_C : '0) - rewind;
        pkt_cnt_d   = pkt_cnt_q + (pkt_inc ? ONE_C : '0) - (pop_last ? ONE_C : '0);
        drop_d      = (drop_inc && drop_q != '1) ? drop_q + CNT_W'(1) : drop_q;
        err_d       = (err_inc && err_q != '1) ? err_q + CNT_W'(1) : err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            wr_start_q  <= '0;
            rd_ptr_q    <= '0;
            used_q      <= '0;
            cur_len_q   <= '0;
            pkt_cnt_q   <= '0;
            out_first_q <= 1'b1;
            drop_q      <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_start_q  <= wr_start_d;
            rd_ptr_q    <= rd_ptr_d;
            used_q      <= used_d;
            cur_len_q   <= cur_len_d;
            pkt_cnt_q   <= pkt_cnt_d;
            out_first_q <= out_first_d;
            drop_q      <= drop_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_osd_dii_pkt_fifo.sv
// Directed bench for the DII packet buffer: a DEPTH=16 instance (a) and a DEPTH=8 instance (b).
module tb_osd_dii_pkt_fifo;
    import osd_dii_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [17:0] exp_qa[$];
    logic [17:0] exp_qb[$];

    logic [15:0] in_data_a = '0, in_data_b = '0;
    logic        in_first_a = 1'b0, in_first_b = 1'b0;
    logic        in_last_a = 1'b0, in_last_b = 1'b0;
    logic        in_valid_a = 1'b0, in_valid_b = 1'b0;
    logic        in_ready_a, in_ready_b;
    logic [15:0] out_data_a, out_data_b;
    logic        out_first_a, out_first_b, out_last_a, out_last_b;
    logic        out_valid_a, out_valid_b;
    logic        out_ready_a = 1'b0, out_ready_b = 1'b0;
    logic [7:0]  drop_count_a, drop_count_b, err_count_a, err_count_b;
    fsm_state_e  dbg_state_a, dbg_state_b;
    logic [4:0]  dbg_used_a;
    logic [3:0]  dbg_used_b;

    osd_dii_pkt_fifo #(.DEPTH(16), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data_a), .in_first(in_first_a), .in_last(in_last_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .out_data(out_data_a), .out_first(out_first_a),
        .out_last(out_last_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .drop_count(drop_count_a), .err_count(err_count_a), .dbg_state_o(dbg_state_a),
        .dbg_used_o(dbg_used_a)
    );

    osd_dii_pkt_fifo #(.DEPTH(8), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data_b), .in_first(in_first_b), .in_last(in_last_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .out_data(out_data_b), .out_first(out_first_b),
        .out_last(out_last_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .drop_count(drop_count_b), .err_count(err_count_b), .dbg_state_o(dbg_state_b),
        .dbg_used_o(dbg_used_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboards: compare every flit the ring takes against the oldest expected flit.
    always @(negedge clk) begin
        if (!rst && out_valid_a && out_ready_a) begin
            if (exp_qa.size() == 0) begin
                n_vec++; n_err++;
                $error("FAIL a_unexpected_flit observed=%0h expected=none", {out_first_a, out_last_a, out_data_a});
            end else begin
                chk("a_flit", {14'd0, out_first_a, out_last_a, out_data_a}, {14'd0, exp_qa.pop_front()});
            end
        end
        if (!rst && out_valid_b && out_ready_b) begin
            if (exp_qb.size() == 0) begin
                n_vec++; n_err++;
                $error("FAIL b_unexpected_flit observed=%0h expected=none", {out_first_b, out_last_b, out_data_b});
            end else begin
                chk("b_flit", {14'd0, out_first_b, out_last_b, out_data_b}, {14'd0, exp_qb.pop_front()});
            end
        end
    end

    // Entered and left at posedge+1; returns the number of cycles the flit was offered.
    task automatic send_a(input logic [15:0] d, input logic f, input logic l, input logic keep,
                          output int cyc);
        logic ok;
        in_data_a = d; in_first_a = f; in_last_a = l; in_valid_a = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk); ok = in_ready_a;
            @(posedge clk); #1; cyc++;
        end while (!ok && cyc < 300);
        in_valid_a = 1'b0;
        if (!ok) begin
            n_vec++; n_err++;
            $error("FAIL a_send_timeout observed=stalled expected=accepted data=%0h", d);
        end else if (keep) begin
            exp_qa.push_back({f, l, d});
        end
    endtask

    task automatic send_b(input logic [15:0] d, input logic f, input logic l, input logic keep,
                          output int cyc);
        logic ok;
        in_data_b = d; in_first_b = f; in_last_b = l; in_valid_b = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk); ok = in_ready_b;
            @(posedge clk); #1; cyc++;
        end while (!ok && cyc < 300);
        in_valid_b = 1'b0;
        if (!ok) begin
            n_vec++; n_err++;
            $error("FAIL b_send_timeout observed=stalled expected=accepted data=%0h", d);
        end else if (keep) begin
            exp_qb.push_back({f, l, d});
        end
    endtask

    task automatic wait_drain();
        int cyc = 0;
        while ((exp_qa.size() != 0 || exp_qb.size() != 0) && cyc < 500) begin
            @(posedge clk); #1; cyc++;
        end
        if (exp_qa.size() != 0 || exp_qb.size() != 0) begin
            n_vec++; n_err++;
            $error("FAIL drain_timeout observed=%0d/%0d left expected=0/0", exp_qa.size(), exp_qb.size());
        end
    endtask

    initial begin
        int c;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready_a), 32'd0);
        chk("rst_out_valid", 32'(out_valid_a), 32'd0);
        chk("rst_out_first", 32'(out_first_a), 32'd1);
        chk("rst_counts", {16'd0, drop_count_a, err_count_a}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 3-flit packet, nothing visible before completion
        out_ready_a = 1'b1;
        send_a(16'h0001, 1'b1, 1'b0, 1'b1, c);
        @(negedge clk); chk("lat_before_2", 32'(out_valid_a), 32'd0);
        @(posedge clk); #1;
        send_a(16'h0002, 1'b0, 1'b0, 1'b1, c);
        @(negedge clk); chk("lat_before_3", 32'(out_valid_a), 32'd0);
        @(posedge clk); #1;
        send_a(16'h0003, 1'b0, 1'b1, 1'b1, c);
        @(negedge clk); chk("lat_valid_after_last", 32'(out_valid_a), 32'd1);
        @(posedge clk); #1;
        wait_drain();
        @(negedge clk); chk("lat_empty_after_drain", 32'(out_valid_a), 32'd0);
        @(posedge clk); #1;

        // Backpressure: two 6-flit packets then a third that stalls after flit 4
        out_ready_a = 1'b0;
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 6; i++)
                send_a(16'h0100 * (p + 1) + 16'(i), i == 0, i == 5, 1'b1, c);
        for (int i = 0; i < 4; i++)
            send_a(16'h0300 + 16'(i), i == 0, 1'b0, 1'b1, c);
        chk("bp_used_full", 32'(dbg_used_a), 32'd16);
        in_data_a = 16'h0304; in_first_a = 1'b0; in_last_a = 1'b0; in_valid_a = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); chk("bp_in_ready_low", 32'(in_ready_a), 32'd0);
        end
        @(posedge clk); #1;
        out_ready_a = 1'b1;
        send_a(16'h0304, 1'b0, 1'b0, 1'b1, c);
        send_a(16'h0305, 1'b0, 1'b1, 1'b1, c);
        wait_drain();

        // Framing error: second first flit restarts the packet
        send_a(16'h0010, 1'b1, 1'b0, 1'b0, c);
        send_a(16'h0011, 1'b0, 1'b0, 1'b0, c);
        send_a(16'h0020, 1'b1, 1'b0, 1'b1, c);
        send_a(16'h0021, 1'b0, 1'b1, 1'b1, c);
        wait_drain();
        chk("frame_err_count", 32'(err_count_a), 32'd1);

        // Stray continuation flit in IDLE
        send_a(16'h1234, 1'b0, 1'b0, 1'b0, c);
        chk("stray_accept_cycles", 32'(c), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); chk("stray_out_valid", 32'(out_valid_a), 32'd0);
        end
        chk("stray_err_count", 32'(err_count_a), 32'd2);
        chk("stray_used", 32'(dbg_used_a), 32'd0);
        @(posedge clk); #1;

        // Oversized packet on DEPTH=8 is dropped with in_ready held high
        out_ready_b = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send_b(16'h0500 + 16'(i), i == 0, i == 9, 1'b0, c);
            chk("drop_in_ready_high", 32'(c), 32'd1);
            if (i == 8) chk("drop_state", 32'(dbg_state_b), 32'(DROP));
        end
        send_b(16'hAAAA, 1'b1, 1'b0, 1'b1, c);
        send_b(16'hBBBB, 1'b0, 1'b1, 1'b1, c);
        wait_drain();
        chk("drop_count", 32'(drop_count_b), 32'd1);
        chk("drop_err_count", 32'(err_count_b), 32'd0);

        // Async reset with a stored packet and a half-written one
        out_ready_a = 1'b0;
        send_a(16'h0600, 1'b1, 1'b1, 1'b0, c);
        send_a(16'h0700, 1'b1, 1'b0, 1'b0, c);
        send_a(16'h0701, 1'b0, 1'b0, 1'b0, c);
        chk("pre_rst_out_valid", 32'(out_valid_a), 32'd1);
        chk("pre_rst_used", 32'(dbg_used_a), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_out_valid", 32'(out_valid_a), 32'd0);
        chk("rst_async_in_ready", 32'(in_ready_a), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post_rst_used", 32'(dbg_used_a), 32'd0);
        chk("post_rst_err", 32'(err_count_a), 32'd0);
        chk("post_rst_drop", 32'(drop_count_b), 32'd0);
        chk("post_rst_state", 32'(dbg_state_a), 32'(IDLE));
        out_ready_a = 1'b1;
        send_a(16'h0777, 1'b1, 1'b1, 1'b1, c);
        @(negedge clk); chk("post_rst_valid", 32'(out_valid_a), 32'd1);
        @(posedge clk); #1;
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
